// File: rtl/serial_frame_tx.sv
// UART-style frame transmitter: start bit, DATA_W data bits LSB first, optional parity, stop bit.
// Latency: the line drops to the start bit the cycle after the accept edge; the frame lasts (2+DATA_W+PARITY_EN)*CLKS_PER_BIT cycles.
// Backpressure: tx_ready is high only in IDLE; tx_valid is ignored while a frame is in flight, so the producer holds it until ready.
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_serial,
    output logic              tx_busy,
    output logic              tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    localparam logic          PAR_INV   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     baud_q;
    logic [BW-1:0]     bit_q;
    logic [DATA_W-1:0] shreg_q;
    logic [DATA_W-1:0] shreg_d;
    logic              par_q;
    logic              ser_q;
    logic              done_q;
    logic              baud_last;

    // Shift-register contents after the next data-bit boundary.
    assign shreg_d   = shreg_q >> 1;
    assign baud_last = (baud_q == BAUD_LAST);

    assign tx_ready  = (state_q == S_IDLE);
    assign tx_busy   = (state_q != S_IDLE);
    assign tx_serial = ser_q;
    assign tx_done   = done_q;

    // Frame sequencer: the line level is registered one step ahead so it changes exactly on state changes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            ser_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    ser_q  <= 1'b1;
                    baud_q <= '0;
                    bit_q  <= '0;
                    if (tx_valid) begin
                        // Parity is captured here because the shift register is consumed by shifting.
                        shreg_q <= tx_data;
                        par_q   <= (^tx_data) ^ PAR_INV;
                        ser_q   <= 1'b0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        ser_q   <= shreg_q[0];
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_q == BIT_LAST) begin
                            bit_q <= '0;
                            if (PARITY_EN != 0) begin
                                ser_q   <= par_q;
                                state_q <= S_PARITY;
                            end else begin
                                ser_q   <= 1'b1;
                                state_q <= S_STOP;
                            end
                        end else begin
                            bit_q   <= bit_q + BW'(1);
                            shreg_q <= shreg_d;
                            ser_q   <= shreg_d[0];
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        ser_q   <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                S_STOP: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        ser_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                default: begin
                    ser_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: four instances (default, even parity, odd parity, one clock per bit).
// Stimulus pushes expected frames; a line monitor decodes each frame and checks bits, timing and tx_done.
// All waits are cycle-bounded.
module tb_serial_frame_tx;

    typedef struct {
        logic [10:0] bits;
        int          start;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] dat [4];
    logic       vld [4];
    logic       rdy [4];
    logic       ser [4];
    logic       busy[4];
    logic       done[4];

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t expq[4][$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u_def (
        .clk(clk), .rst_n(rst_n), .tx_data(dat[0]), .tx_valid(vld[0]), .tx_ready(rdy[0]),
        .tx_serial(ser[0]), .tx_busy(busy[0]), .tx_done(done[0]));
    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_pe (
        .clk(clk), .rst_n(rst_n), .tx_data(dat[1]), .tx_valid(vld[1]), .tx_ready(rdy[1]),
        .tx_serial(ser[1]), .tx_busy(busy[1]), .tx_done(done[1]));
    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_po (
        .clk(clk), .rst_n(rst_n), .tx_data(dat[2]), .tx_valid(vld[2]), .tx_ready(rdy[2]),
        .tx_serial(ser[2]), .tx_busy(busy[2]), .tx_done(done[2]));
    serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) u_fast (
        .clk(clk), .rst_n(rst_n), .tx_data(dat[3]), .tx_valid(vld[3]), .tx_ready(rdy[3]),
        .tx_serial(ser[3]), .tx_busy(busy[3]), .tx_done(done[3]));

    function automatic int cpb_of(int i);
        return (i == 3) ? 1 : 4;
    endfunction

    function automatic int nbits_of(int i);
        return (i == 1 || i == 2) ? 11 : 10;
    endfunction

    // Line levels in transmit order, bit 0 first; p is the hand-computed parity bit.
    function automatic logic [10:0] mkframe(logic [7:0] d, bit par_en, bit p);
        logic [10:0] f;
        f      = '0;
        f[8:1] = d;
        if (par_en) begin
            f[9]  = p;
            f[10] = 1'b1;
        end else begin
            f[9] = 1'b1;
        end
        return f;
    endfunction

    task automatic check(string nm, int inst, bit ok, logic [15:0] act, logic [15:0] exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s inst%0d: got %h expected %h (cycle %0d)", nm, inst, act, exp, cyc);
        end
    endtask

    // Drive one word with tx_valid held until the DUT is ready; records the expected frame.
    task automatic send(int i, logic [7:0] d, logic [10:0] bits, output int st);
        int guard;
        guard  = 0;
        dat[i] = d;
        vld[i] = 1'b1;
        while (rdy[i] !== 1'b1 && guard < 200) begin
            @(negedge clk); #1;
            guard++;
        end
        check("ready_timeout", i, guard < 200, 16'(guard), 16'd0);
        st = cyc + 1;
        expq[i].push_back('{bits: bits, start: st});
        @(negedge clk); #1;
        vld[i] = 1'b0;
    endtask

    task automatic wait_until(int t);
        while (cyc < t) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic idle_cycles(int n);
        repeat (n) begin
            @(negedge clk); #1;
        end
    endtask

    // Monitor state, one slot per instance.
    bit          in_frame[4];
    bit          end_pend[4];
    bit          win_ok  [4];
    int          fcyc    [4];
    int          fstart  [4];
    logic [10:0] got     [4];
    int          mk, mc, mb;
    exp_t        me;

    // Decode the serial lines into frames and compare against the expected queues.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst_n !== 1'b1) begin
                if (in_frame[i]) begin
                    in_frame[i] = 1'b0;
                    if (expq[i].size() > 0) me = expq[i].pop_front();
                end
                end_pend[i] = 1'b0;
            end else if (end_pend[i]) begin
                end_pend[i] = 1'b0;
                check("done_pulse", i,
                      done[i] === 1'b1 && busy[i] === 1'b0 && rdy[i] === 1'b1 && ser[i] === 1'b1,
                      {12'd0, done[i], busy[i], rdy[i], ser[i]}, 16'b1011);
            end else begin
                if (!in_frame[i]) begin
                    if (done[i] === 1'b1) begin
                        check("stray_done", i, 1'b0, 16'd1, 16'd0);
                    end else if (ser[i] === 1'b0) begin
                        in_frame[i] = 1'b1;
                        fcyc[i]     = 0;
                        got[i]      = '0;
                        fstart[i]   = cyc;
                        win_ok[i]   = 1'b1;
                    end
                end
                if (in_frame[i]) begin
                    mk = fcyc[i];
                    mc = cpb_of(i);
                    mb = mk / mc;
                    if (mk % mc == 0) got[i][mb] = ser[i];
                    else if (ser[i] !== got[i][mb]) win_ok[i] = 1'b0;
                    if (busy[i] !== 1'b1 || rdy[i] !== 1'b0 || done[i] !== 1'b0) win_ok[i] = 1'b0;
                    if (mk == nbits_of(i) * mc - 1) begin
                        if (expq[i].size() == 0) begin
                            check("unexpected_frame", i, 1'b0, {5'd0, got[i]}, 16'd0);
                        end else begin
                            me = expq[i].pop_front();
                            check("frame_bits", i, got[i] == me.bits, {5'd0, got[i]}, {5'd0, me.bits});
                            check("frame_start", i, fstart[i] == me.start, 16'(fstart[i]), 16'(me.start));
                        end
                        check("busy_window", i, win_ok[i], {15'd0, win_ok[i]}, 16'd1);
                        in_frame[i] = 1'b0;
                        end_pend[i] = 1'b1;
                    end
                    fcyc[i] = fcyc[i] + 1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s1, s2;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dat[i] = 8'hFF;
            vld[i] = 1'b1;
        end

        // Reset held for two edges with tx_valid high: everything stays idle.
        for (int e = 0; e < 2; e++) begin
            @(negedge clk); #1;
            for (int i = 0; i < 4; i++)
                check("reset_state", i, {ser[i], rdy[i], busy[i], done[i]} === 4'b1100,
                      {12'd0, ser[i], rdy[i], busy[i], done[i]}, 16'b1100);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) vld[i] = 1'b0;
        idle_cycles(5);
        for (int i = 0; i < 4; i++)
            check("idle_after_reset", i, {ser[i], rdy[i], busy[i], done[i]} === 4'b1100,
                  {12'd0, ser[i], rdy[i], busy[i], done[i]}, 16'b1100);

        // Default frame of A5: line per bit 0,1,0,1,0,0,1,0,1,1.
        send(0, 8'hA5, 11'h34A, s1);
        dat[0] = 8'h00;
        wait_until(s1 + 48);

        // Parity variants.
        send(1, 8'hA5, mkframe(8'hA5, 1'b1, 1'b0), s1);
        send(2, 8'hA5, mkframe(8'hA5, 1'b1, 1'b1), s2);
        wait_until(s2 + 48);
        send(1, 8'h07, mkframe(8'h07, 1'b1, 1'b1), s1);
        wait_until(s1 + 48);

        // Back-to-back at one clock per bit; tx_data changes mid-frame.
        dat[3] = 8'h01;
        vld[3] = 1'b1;
        while (rdy[3] !== 1'b1) begin
            @(negedge clk); #1;
        end
        s1 = cyc + 1;
        expq[3].push_back('{bits: mkframe(8'h01, 1'b0, 1'b0), start: s1});
        expq[3].push_back('{bits: mkframe(8'h80, 1'b0, 1'b0), start: s1 + 11});
        @(negedge clk); #1;
        dat[3] = 8'h80;
        s2 = 0;
        while (rdy[3] !== 1'b1 && s2 < 50) begin
            @(negedge clk); #1;
            s2++;
        end
        check("b2b_ready_timeout", 3, s2 < 50, 16'(s2), 16'd0);
        @(negedge clk); #1;
        vld[3] = 1'b0;
        dat[3] = 8'h00;
        wait_until(s1 + 30);

        // Busy ignore: a pulse of 55 mid-frame must not be sent.
        send(0, 8'h0F, mkframe(8'h0F, 1'b0, 1'b0), s1);
        wait_until(s1 + 12);
        dat[0] = 8'h55;
        vld[0] = 1'b1;
        idle_cycles(1);
        vld[0] = 1'b0;
        dat[0] = 8'h00;
        wait_until(s1 + 60);

        // Reset during data bit 3 of FF, then a clean 3C frame.
        send(0, 8'hFF, mkframe(8'hFF, 1'b0, 1'b0), s1);
        wait_until(s1 + 17);
        rst_n = 1'b0;
        idle_cycles(1);
        check("abort_state", 0, {ser[0], rdy[0], busy[0], done[0]} === 4'b1100,
              {12'd0, ser[0], rdy[0], busy[0], done[0]}, 16'b1100);
        rst_n = 1'b1;
        idle_cycles(1);
        check("abort_no_done", 0, done[0] === 1'b0 && busy[0] === 1'b0,
              {14'd0, done[0], busy[0]}, 16'd0);
        send(0, 8'h3C, mkframe(8'h3C, 1'b0, 1'b0), s1);
        wait_until(s1 + 60);

        for (int i = 0; i < 4; i++)
            check("frames_pending", i, expq[i].size() == 0, 16'(expq[i].size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
